// File: rtl/iram_fetch_arbiter.sv
// Instruction RAM fetch arbiter.
// Shares the single registered read port of the iram between the core fetch
// unit and the debug readback port. One transaction is in flight at a time;
// each response appears three cycles after its request is accepted.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | nothing in flight, arbitrate incoming requests
// S_ISSUE   | im_r/iram_addr driven for the accepted request
// S_CAPTURE | RAM data valid, capture it into the owner's rsp_data
// S_RESP    | owner's rsp_valid high; on handshake accept the next request
module iram_fetch_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 129,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_core_req_valid,
  output logic              o_core_req_ready,
  input  logic [ADDR_W-1:0] i_core_req_addr,
  output logic              o_core_rsp_valid,
  input  logic              i_core_rsp_ready,
  output logic [DATA_W-1:0] o_core_rsp_data,
  input  logic              i_core_flush,
  input  logic              i_dbg_req_valid,
  output logic              o_dbg_req_ready,
  input  logic [ADDR_W-1:0] i_dbg_req_addr,
  output logic              o_dbg_rsp_valid,
  input  logic              i_dbg_rsp_ready,
  output logic [DATA_W-1:0] o_dbg_rsp_data,
  output logic              o_im_r,
  output logic [ADDR_W-1:0] o_iram_addr,
  input  logic [DATA_W-1:0] i_instr_out
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]   STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [ADDR_W:0]   DEPTH_X    = (ADDR_W + 1)'(DEPTH);
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_owner;
  logic              r_oor;
  logic              r_im_r;
  logic [ADDR_W-1:0] r_iram_addr;
  logic              r_core_rsp_valid;
  logic              r_dbg_rsp_valid;
  logic [DATA_W-1:0] r_core_rsp_data;
  logic [DATA_W-1:0] r_dbg_rsp_data;
  logic [SC_W-1:0]   r_starve_cnt;

  logic              w_rsp_ready;
  logic              w_flush_hit;
  logic              w_arb_slot;
  logic              w_starved;
  logic              w_dbg_win;
  logic              w_core_grant;
  logic              w_dbg_grant;
  logic [ADDR_W-1:0] w_grant_addr;
  logic              w_grant_oor;

  // Arbitration and flush decode; grants are only possible in IDLE or on a RESP handshake
  always_comb begin
    w_rsp_ready  = (r_owner == OWN_DBG) ? i_dbg_rsp_ready : i_core_rsp_ready;
    w_flush_hit  = i_core_flush && (r_owner == OWN_CORE) && (r_state != S_IDLE);
    w_arb_slot   = (r_state == S_IDLE) ||
                   ((r_state == S_RESP) && w_rsp_ready && !w_flush_hit);
    w_starved    = (r_starve_cnt == STARVE_MAX);
    w_dbg_win    = i_dbg_req_valid && (!i_core_req_valid || w_starved);
    w_core_grant = w_arb_slot && i_core_req_valid && !w_dbg_win;
    w_dbg_grant  = w_arb_slot && w_dbg_win;
    w_grant_addr = w_dbg_win ? i_dbg_req_addr : i_core_req_addr;
    w_grant_oor  = ({1'b0, w_grant_addr} >= DEPTH_X);
  end

  assign o_core_req_ready = w_arb_slot && !w_dbg_win;
  assign o_dbg_req_ready  = w_dbg_grant;
  // A flush in RESP must hide the core response in that very cycle
  assign o_core_rsp_valid = r_core_rsp_valid && !i_core_flush;
  assign o_core_rsp_data  = r_core_rsp_data;
  assign o_dbg_rsp_valid  = r_dbg_rsp_valid;
  assign o_dbg_rsp_data   = r_dbg_rsp_data;
  assign o_im_r           = r_im_r;
  assign o_iram_addr      = r_iram_addr;

  // Transaction sequencer: state, RAM port, response registers and starvation counter
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_owner          <= OWN_CORE;
      r_oor            <= 1'b0;
      r_im_r           <= 1'b0;
      r_iram_addr      <= '0;
      r_core_rsp_valid <= 1'b0;
      r_dbg_rsp_valid  <= 1'b0;
      r_core_rsp_data  <= '0;
      r_dbg_rsp_data   <= '0;
      r_starve_cnt     <= '0;
    end else begin
      r_im_r <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        S_ISSUE: begin
          r_state <= w_flush_hit ? S_IDLE : S_CAPTURE;
        end
        S_CAPTURE: begin
          if (w_flush_hit) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RESP;
            if (r_owner == OWN_DBG) begin
              r_dbg_rsp_valid <= 1'b1;
              r_dbg_rsp_data  <= r_oor ? '0 : i_instr_out;
            end else begin
              r_core_rsp_valid <= 1'b1;
              r_core_rsp_data  <= r_oor ? '0 : i_instr_out;
            end
          end
        end
        S_RESP: begin
          if (w_flush_hit) begin
            r_core_rsp_valid <= 1'b0;
            r_state          <= S_IDLE;
          end else if (w_rsp_ready) begin
            if (r_owner == OWN_DBG) r_dbg_rsp_valid <= 1'b0;
            else                    r_core_rsp_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A grant overrides the IDLE/RESP next-state chosen above
      if (w_core_grant || w_dbg_grant) begin
        r_state <= S_ISSUE;
        r_owner <= w_dbg_grant ? OWN_DBG : OWN_CORE;
        r_oor   <= w_grant_oor;
        r_im_r  <= !w_grant_oor;
        if (!w_grant_oor) r_iram_addr <= w_grant_addr;
        if (w_dbg_grant) begin
          r_starve_cnt <= '0;
        end else if (i_dbg_req_valid && !w_starved) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iram_fetch_arbiter.sv
// Directed bench for iram_fetch_arbiter with a behavioural registered RAM.
module tb_iram_fetch_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 129;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_req_valid, core_req_ready, core_rsp_valid, core_rsp_ready, core_flush;
  logic [ADDR_W-1:0] core_req_addr;
  logic [DATA_W-1:0] core_rsp_data;
  logic              dbg_req_valid, dbg_req_ready, dbg_rsp_valid, dbg_rsp_ready;
  logic [ADDR_W-1:0] dbg_req_addr;
  logic [DATA_W-1:0] dbg_rsp_data;
  logic              im_r;
  logic [ADDR_W-1:0] iram_addr;
  logic [DATA_W-1:0] instr_out = '0;
  logic [DATA_W-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  iram_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(4)) dut (
    .i_clock(clk), .i_reset(reset),
    .i_core_req_valid(core_req_valid), .o_core_req_ready(core_req_ready),
    .i_core_req_addr(core_req_addr), .o_core_rsp_valid(core_rsp_valid),
    .i_core_rsp_ready(core_rsp_ready), .o_core_rsp_data(core_rsp_data),
    .i_core_flush(core_flush),
    .i_dbg_req_valid(dbg_req_valid), .o_dbg_req_ready(dbg_req_ready),
    .i_dbg_req_addr(dbg_req_addr), .o_dbg_rsp_valid(dbg_rsp_valid),
    .i_dbg_rsp_ready(dbg_rsp_ready), .o_dbg_rsp_data(dbg_rsp_data),
    .o_im_r(im_r), .o_iram_addr(iram_addr), .i_instr_out(instr_out)
  );

  // registered-read RAM model
  always @(posedge clk) begin
    if (im_r && (int'(iram_addr) < DEPTH)) instr_out <= mem[iram_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  logic exp_dbg [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int   n_grant;
  logic seen;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i * 32'h0001_0101;
    mem[5] = 32'hDEADBEEF;
    reset = 1'b1;
    core_req_valid = 0; core_req_addr = '0; core_rsp_ready = 0; core_flush = 0;
    dbg_req_valid = 0; dbg_req_addr = '0; dbg_rsp_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_im_r", im_r, 0);
    check("rst_addr", iram_addr, 0);
    check("rst_core_valid", core_rsp_valid, 0);
    check("rst_dbg_valid", dbg_rsp_valid, 0);
    check("rst_core_data", core_rsp_data, 0);
    reset = 1'b0;

    // 1: single core fetch of addr 5
    @(negedge clk); core_req_valid = 1; core_req_addr = 10'd5; core_rsp_ready = 1;
    #1 check("t1_accept", core_req_ready, 1);
    @(negedge clk); core_req_valid = 0;
    #1 check("t1_im_r", im_r, 1); check("t1_addr", iram_addr, 5); check("t1_novalid1", core_rsp_valid, 0);
    @(negedge clk);
    #1 check("t1_im_r_low", im_r, 0); check("t1_novalid2", core_rsp_valid, 0);
    @(negedge clk);
    #1 check("t1_valid", core_rsp_valid, 1); check("t1_data", core_rsp_data, 32'hDEADBEEF);
    @(negedge clk);
    #1 check("t1_done", core_rsp_valid, 0);

    // 2: both ports continuously requesting
    core_req_valid = 1; core_req_addr = 10'd10; dbg_req_valid = 1; dbg_req_addr = 10'd20;
    dbg_rsp_ready = 1;
    n_grant = 0;
    for (int c = 0; c < 60 && n_grant < 10; c++) begin
      #1;
      if (core_req_ready && core_req_valid) begin
        check($sformatf("t2_grant%0d_core", n_grant), 0, exp_dbg[n_grant]);
        n_grant++;
      end else if (dbg_req_ready) begin
        check($sformatf("t2_grant%0d_dbg", n_grant), 1, exp_dbg[n_grant]);
        n_grant++;
      end
      if (core_rsp_valid) check("t2_core_data", core_rsp_data, mem[10]);
      if (dbg_rsp_valid)  check("t2_dbg_data", dbg_rsp_data, mem[20]);
      @(negedge clk);
    end
    check("t2_grant_count", n_grant, 10);
    core_req_valid = 0; dbg_req_valid = 0;
    repeat (4) @(negedge clk);

    // 3: response back-pressure, then back-to-back accept
    core_req_valid = 1; core_req_addr = 10'd7; core_rsp_ready = 0;
    #1 check("t3_accept", core_req_ready, 1);
    @(negedge clk); core_req_addr = 10'd8;
    #1 check("t3_busy", core_req_ready, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("t3_hold_valid%0d", k), core_rsp_valid, 1);
      check($sformatf("t3_hold_data%0d", k), core_rsp_data, mem[7]);
      check($sformatf("t3_hold_im_r%0d", k), im_r, 0);
      check($sformatf("t3_hold_ready%0d", k), core_req_ready, 0);
    end
    @(negedge clk); core_rsp_ready = 1;
    #1 check("t3_b2b_accept", core_req_ready, 1);
    @(negedge clk); core_req_valid = 0;
    #1 check("t3_b2b_im_r", im_r, 1); check("t3_b2b_addr", iram_addr, 8); check("t3_valid_drop", core_rsp_valid, 0);
    @(negedge clk);
    @(negedge clk);
    #1 check("t3_b2b_valid", core_rsp_valid, 1); check("t3_b2b_data", core_rsp_data, mem[8]);
    @(negedge clk);

    // 5: out-of-range address
    core_req_valid = 1; core_req_addr = 10'd200;
    #1 check("t5_accept", core_req_ready, 1);
    @(negedge clk); core_req_valid = 0;
    #1 check("t5_no_im_r1", im_r, 0);
    @(negedge clk);
    #1 check("t5_no_im_r2", im_r, 0);
    @(negedge clk);
    #1 check("t5_valid", core_rsp_valid, 1); check("t5_data", core_rsp_data, 0);
    @(negedge clk);

    // 4: flush in CAPTURE, then new request from IDLE
    core_req_valid = 1; core_req_addr = 10'd30;
    #1 check("t4_accept", core_req_ready, 1);
    @(negedge clk); core_req_valid = 0;
    @(negedge clk); core_flush = 1; core_req_valid = 1; core_req_addr = 10'd31;
    #1 check("t4_flush_novalid", core_rsp_valid, 0); check("t4_flush_noaccept", core_req_ready, 0);
    @(negedge clk); core_flush = 0;
    #1 check("t4_idle_novalid", core_rsp_valid, 0); check("t4_new_accept", core_req_ready, 1);
    @(negedge clk); core_req_valid = 0;
    #1 check("t4_new_im_r", im_r, 1); check("t4_new_addr", iram_addr, 31);
    @(negedge clk);
    @(negedge clk);
    #1 check("t4_new_valid", core_rsp_valid, 1); check("t4_new_data", core_rsp_data, mem[31]);
    @(negedge clk);

    // 4b: flush while in RESP
    core_req_valid = 1; core_req_addr = 10'd40; core_rsp_ready = 0;
    #1 check("t4b_accept", core_req_ready, 1);
    @(negedge clk); core_req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #1 check("t4b_valid", core_rsp_valid, 1); check("t4b_data", core_rsp_data, mem[40]);
    core_flush = 1; core_rsp_ready = 1; core_req_valid = 1; core_req_addr = 10'd41;
    #1 check("t4b_flush_novalid", core_rsp_valid, 0); check("t4b_flush_noaccept", core_req_ready, 0);
    @(negedge clk); core_flush = 0;
    #1 check("t4b_idle_accept", core_req_ready, 1); check("t4b_idle_novalid", core_rsp_valid, 0);
    @(negedge clk); core_req_valid = 0;
    #1 check("t4b_im_r", im_r, 1); check("t4b_addr", iram_addr, 41);
    @(negedge clk);
    @(negedge clk);
    #1 check("t4b_new_data", core_rsp_data, mem[41]); check("t4b_new_valid", core_rsp_valid, 1);
    @(negedge clk);

    // 6: reset during ISSUE
    core_req_valid = 1; core_req_addr = 10'd9;
    #1 check("t6_accept", core_req_ready, 1);
    @(negedge clk); core_req_valid = 0;
    #1 check("t6_im_r", im_r, 1);
    reset = 1;
    @(negedge clk);
    #1;
    check("t6_rst_im_r", im_r, 0);
    check("t6_rst_addr", iram_addr, 0);
    check("t6_rst_valid", core_rsp_valid, 0);
    check("t6_rst_core_data", core_rsp_data, 0);
    check("t6_rst_dbg_data", dbg_rsp_data, 0);
    reset = 0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1 seen = seen | core_rsp_valid | im_r;
    end
    check("t6_no_response", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
